// File: rtl/ptc_deadtime_pkg.sv
// Shared types and constants for the complementary dead-time generator.
// The state encoding is also what state_o reports for debug readback.
package ptc_deadtime_pkg;

  localparam int DTW_DEF = 8;
  localparam int SCW_DEF = 8;

  typedef enum logic [2:0] {
    S_DIS   = 3'd0,
    S_LO    = 3'd1,
    S_DT_LH = 3'd2,
    S_HI    = 3'd3,
    S_DT_HL = 3'd4,
    S_FAULT = 3'd5
  } ptc_dt_state_t;

  // {high-side, low-side} with both drivers off
  localparam logic [1:0] OUT_OFF = 2'b00;

  function automatic logic [1:0] out_decode(input ptc_dt_state_t st);
    logic [1:0] hl;
    case (st)
      S_LO:    hl = 2'b01;
      S_HI:    hl = 2'b10;
      default: hl = OUT_OFF;
    endcase
    return hl;
  endfunction

endpackage

// File: rtl/ptc_deadtime_gen_if.sv
// Control/status bundle between the timer stage and the dead-time generator.
// master drives the PWM and configuration; slave is the generator itself.
interface ptc_deadtime_gen_if
  import ptc_deadtime_pkg::*;
#(
  parameter int DTW = DTW_DEF,
  parameter int SCW = SCW_DEF
);
  logic           pwm_in;
  logic           enable;
  logic [DTW-1:0] dt_rise;
  logic [DTW-1:0] dt_fall;
  logic           out_inv;
  logic           fault_in;
  logic           fault_clr;
  logic           pwm_h;
  logic           pwm_l;
  logic           fault_flag;
  logic [SCW-1:0] swallow_cnt;
  logic [2:0]     state_o;

  modport master (
    output pwm_in, enable, dt_rise, dt_fall, out_inv, fault_in, fault_clr,
    input  pwm_h, pwm_l, fault_flag, swallow_cnt, state_o
  );

  modport slave (
    input  pwm_in, enable, dt_rise, dt_fall, out_inv, fault_in, fault_clr,
    output pwm_h, pwm_l, fault_flag, swallow_cnt, state_o
  );
endinterface

// File: rtl/ptc_dt_counter.sv
// Loadable down-counter timing one dead-time interval.
// expire goes high during the last cycle of an interval of ld_val cycles.
module ptc_dt_counter
  import ptc_deadtime_pkg::*;
#(
  parameter int DTW = DTW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           run,
  input  logic [DTW-1:0] ld_val,
  output logic           expire
);

  localparam logic [DTW-1:0] ZERO = {DTW{1'b0}};
  localparam logic [DTW-1:0] ONE  = DTW'(1);

  logic [DTW-1:0] cnt_r;
  logic           expire_r;

  // count register; loading ld_val-1 lets expire be registered yet on time
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= ZERO;
      expire_r <= 1'b0;
    end else if (load) begin
      cnt_r    <= (ld_val == ZERO) ? ZERO : ld_val - ONE;
      expire_r <= (ld_val <= ONE);
    end else if (run) begin
      if (cnt_r != ZERO) begin
        cnt_r    <= cnt_r - ONE;
        expire_r <= (cnt_r == ONE);
      end else begin
        expire_r <= 1'b1;
      end
    end else begin
      expire_r <= 1'b0;
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/ptc_deadtime_gen.sv
// Complementary high/low-side PWM generator with dead-time insertion,
// sticky synchronous fault shutdown and a saturating swallowed-pulse counter.
module ptc_deadtime_gen
  import ptc_deadtime_pkg::*;
#(
  parameter int DTW = DTW_DEF,
  parameter int SCW = SCW_DEF
) (
  input logic              clk,
  input logic              rst,
  ptc_deadtime_gen_if.slave bus
);

  localparam logic [DTW-1:0] DT_ZERO = {DTW{1'b0}};
  localparam logic [SCW-1:0] SC_MAX  = {SCW{1'b1}};

  ptc_dt_state_t  state_r;
  ptc_dt_state_t  state_nxt_s;
  logic           pwm_q_r;
  logic [1:0]     hl_r;
  logic           fault_flag_r;
  logic [SCW-1:0] swallow_r;
  logic           swallow_inc_s;
  logic           load_s;
  logic           run_s;
  logic [DTW-1:0] ld_val_s;
  logic           expire_s;

  // next-state decode; fault outranks disable, revert outranks expiry
  always_comb begin
    state_nxt_s   = state_r;
    swallow_inc_s = 1'b0;
    if (bus.fault_in) begin
      state_nxt_s = S_FAULT;
    end else if (state_r == S_FAULT) begin
      state_nxt_s = bus.fault_clr ? S_DIS : S_FAULT;
    end else if (!bus.enable) begin
      state_nxt_s = S_DIS;
    end else begin
      case (state_r)
        S_DIS:   state_nxt_s = pwm_q_r ? ((bus.dt_rise == DT_ZERO) ? S_HI : S_DT_LH) : S_LO;
        S_LO:    state_nxt_s = pwm_q_r ? ((bus.dt_rise == DT_ZERO) ? S_HI : S_DT_LH) : S_LO;
        S_HI:    state_nxt_s = pwm_q_r ? S_HI : ((bus.dt_fall == DT_ZERO) ? S_LO : S_DT_HL);
        S_DT_LH: begin
          if (!pwm_q_r) begin
            state_nxt_s   = S_LO;
            swallow_inc_s = 1'b1;
          end else begin
            state_nxt_s = expire_s ? S_HI : S_DT_LH;
          end
        end
        S_DT_HL: begin
          if (pwm_q_r) begin
            state_nxt_s   = S_HI;
            swallow_inc_s = 1'b1;
          end else begin
            state_nxt_s = expire_s ? S_LO : S_DT_HL;
          end
        end
        default: state_nxt_s = S_DIS;
      endcase
    end
  end

  // the interval length is captured only on entry to a dead-time state
  always_comb begin
    load_s   = ((state_nxt_s == S_DT_LH) && (state_r != S_DT_LH)) ||
               ((state_nxt_s == S_DT_HL) && (state_r != S_DT_HL));
    ld_val_s = (state_nxt_s == S_DT_LH) ? bus.dt_rise : bus.dt_fall;
    run_s    = (state_r == S_DT_LH) || (state_r == S_DT_HL);
  end

  ptc_dt_counter #(.DTW(DTW)) u_dt_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .run    (run_s),
    .ld_val (ld_val_s),
    .expire (expire_s)
  );

  // state, staged input, registered drives, fault latch and swallow counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_DIS;
      pwm_q_r      <= 1'b0;
      hl_r         <= OUT_OFF;
      fault_flag_r <= 1'b0;
      swallow_r    <= {SCW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pwm_q_r <= bus.pwm_in;
      hl_r    <= out_decode(state_nxt_s);
      if (bus.fault_in) begin
        fault_flag_r <= 1'b1;
      end else if ((state_r == S_FAULT) && bus.fault_clr) begin
        fault_flag_r <= 1'b0;
      end else begin
        fault_flag_r <= fault_flag_r;
      end
      if (swallow_inc_s && (swallow_r != SC_MAX)) begin
        swallow_r <= swallow_r + SCW'(1);
      end else begin
        swallow_r <= swallow_r;
      end
    end
  end

  assign bus.pwm_h       = hl_r[1] ^ bus.out_inv;
  assign bus.pwm_l       = hl_r[0] ^ bus.out_inv;
  assign bus.fault_flag  = fault_flag_r;
  assign bus.swallow_cnt = swallow_r;
  assign bus.state_o     = state_r;

endmodule
